mdu_div_ctrl: RTL and testbench

Sequencing controller between the MIPS54 execute stage and the 32-step unsigned restoring divider core (DIVU). It accepts DIV/DIVU requests and converts signed operands to magnitudes. It starts the core, waits for its completion pulse, applies sign correction and commits the results into the architectural HI/LO registers. It also owns MTHI/MTLO writes, drives the pipeline stall (`busy`), and handles divide-by-zero and core-hang cases.

---
 rtl/mdu_div_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mdu_div_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div_ctrl.sv
// mdu_div_ctrl
// Sequencing controller between the execute stage and a 32-step unsigned
// restoring divider core. It turns DIV/DIVU requests into magnitudes and
// starts the core. It waits for the core's completion pulse, then sign-fixes
// the results and commits them to HI/LO. It also owns MTHI/MTLO writes, the
// pipeline stall, divide-by-zero handling and a watchdog for a hung core.
//
// A request is taken on the accept edge with the machine still in IDLE. It
// is held for one cycle in a pending flag before the machine moves to START,
// or straight to FIX for a zero divisor. This gives the fixed latencies seen
// by the pipeline: 36 busy cycles for a real divide and 2 for divide-by-zero.

module mdu_div_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] core_dividend,
    output logic [31:0] core_divisor,
    output logic        core_start,
    input  logic [31:0] core_q,
    input  logic [31:0] core_r,
    input  logic        core_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_FIX   = 2'd3
    } state_t;

    localparam int                 WDOG_W     = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0]  WDOG_LIMIT = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0]  WDOG_ONE   = WDOG_W'(1);
    localparam logic [WDOG_W-1:0]  WDOG_ZERO  = WDOG_W'(0);

    // Magnitude of an operand: two's complement abs when signed, raw
    // otherwise. abs(0x80000000) stays 0x80000000 and is used as unsigned.
    function automatic logic [31:0] f_mag(input logic [31:0] v, input logic sgn);
        logic [31:0] m;
        if (sgn && v[31]) begin
            m = (~v) + 32'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Conditional 32-bit two's complement negation used for sign correction.
    function automatic logic [31:0] f_fix(input logic [31:0] v, input logic neg);
        logic [31:0] f;
        if (neg) begin
            f = (~v) + 32'd1;
        end else begin
            f = v;
        end
        return f;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_pend;
    logic              r_div0;
    logic              r_qneg;
    logic              r_rneg;
    logic [31:0]       r_dvd;
    logic [31:0]       r_dvs;
    logic [31:0]       r_q;
    logic [31:0]       r_r;
    logic [WDOG_W-1:0] r_wdog;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_core_start;

    logic              w_accept;
    logic              w_idle_free;
    logic [WDOG_W-1:0] w_wdog_inc;
    logic              w_timeout;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_core_start_nxt;

    // A fresh request is only taken in IDLE with nothing pending; MTHI/MTLO
    // share the same window.
    assign w_idle_free = (r_state == S_IDLE) && !r_pend;
    assign w_accept    = w_idle_free && div_req;
    assign w_wdog_inc  = r_wdog + WDOG_ONE;
    assign w_timeout   = (r_state == S_WAIT) && !core_done && (w_wdog_inc == WDOG_LIMIT);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_pend) begin
                    if (r_div0) begin
                        w_state_nxt = S_FIX;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    w_state_nxt = S_FIX;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered control outputs.
    always_comb begin
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_err_nxt        = 1'b0;
        w_core_start_nxt = 1'b0;
        if (w_accept) begin
            w_busy_nxt = 1'b1;
        end else begin
            w_busy_nxt = (w_state_nxt != S_IDLE);
        end
        if (r_state == S_FIX) begin
            w_done_nxt = 1'b1;
        end else begin
            w_done_nxt = 1'b0;
        end
        w_err_nxt        = w_timeout;
        w_core_start_nxt = (w_state_nxt == S_START);
    end

    // Output registers: no combinational path from any input to an output.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_core_start <= w_core_start_nxt;
        end
    end

    // Request capture: magnitudes, sign flags and the divide-by-zero result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend <= 1'b0;
            r_div0 <= 1'b0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_dvd  <= 32'd0;
            r_dvs  <= 32'd0;
        end else if (w_accept) begin
            r_pend <= 1'b1;
            r_dvd  <= f_mag(rs_data, div_signed);
            r_dvs  <= f_mag(rt_data, div_signed);
            if (rt_data == 32'd0) begin
                r_div0 <= 1'b1;
                r_qneg <= 1'b0;
                r_rneg <= 1'b0;
            end else begin
                r_div0 <= 1'b0;
                r_qneg <= div_signed & (rs_data[31] ^ rt_data[31]);
                r_rneg <= div_signed & rs_data[31];
            end
        end else begin
            r_pend <= 1'b0;
        end
    end

    // Raw quotient/remainder: fixed on divide-by-zero, captured from the core
    // on its done pulse; the watchdog runs only while waiting on the core.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q    <= 32'd0;
            r_r    <= 32'd0;
            r_wdog <= WDOG_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (rt_data == 32'd0)) begin
                        r_q <= 32'hFFFF_FFFF;
                        r_r <= rs_data;
                    end else begin
                        r_q <= r_q;
                    end
                end
                S_START: begin
                    r_wdog <= WDOG_ZERO;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_q <= core_q;
                        r_r <= core_r;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                S_FIX: begin
                    r_wdog <= r_wdog;
                end
                default: begin
                    r_wdog <= WDOG_ZERO;
                end
            endcase
        end
    end

    // Architectural HI/LO: divide commit in FIX, MTHI/MTLO only when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_state == S_FIX) begin
            r_lo <= f_fix(r_q, r_qneg);
            r_hi <= f_fix(r_r, r_rneg);
        end else if (w_idle_free) begin
            if (hi_we) begin
                r_hi <= wdata;
            end else begin
                r_hi <= r_hi;
            end
            if (lo_we) begin
                r_lo <= wdata;
            end else begin
                r_lo <= r_lo;
            end
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign hi            = r_hi;
    assign lo            = r_lo;
    assign core_start    = r_core_start;
    assign core_dividend = r_dvd;
    assign core_divisor  = r_dvs;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Self-checking bench for mdu_div_ctrl with a behavioural 32-step divider core.
// Expected HI/LO come from a 64-bit reference divide and are queued at issue
// time, then popped when the controller pulses done.

module tb_mdu_div_ctrl;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        div_req;
    logic        div_signed;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] core_dividend;
    logic [31:0] core_divisor;
    logic        core_start;
    logic [31:0] core_q;
    logic [31:0] core_r;
    logic        core_done;

    mdu_div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .div_req(div_req), .div_signed(div_signed),
        .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo),
        .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_start(core_start), .core_q(core_q), .core_r(core_r),
        .core_done(core_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural core: samples start, raises done 32 edges later.
    logic        core_hang = 1'b0;
    int          core_cnt;
    logic [31:0] core_a;
    logic [31:0] core_b;
    always @(posedge clock) begin
        if (reset) begin
            core_cnt  <= 0;
            core_done <= 1'b0;
            core_q    <= 32'd0;
            core_r    <= 32'd0;
            core_a    <= 32'd0;
            core_b    <= 32'd1;
        end else begin
            core_done <= 1'b0;
            if (core_start) begin
                core_cnt <= 32;
                core_a   <= core_dividend;
                core_b   <= core_divisor;
            end else if (core_cnt > 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1 && !core_hang) begin
                    core_done <= 1'b1;
                    core_q    <= core_a / core_b;
                    core_r    <= core_a % core_b;
                end
            end
        end
    end

    typedef struct {
        logic [63:0] res;
        int          e0;
        int          lat;
        int          starts;
    } sb_t;
    sb_t sb[$];

    int n_chk = 0;
    int n_pass = 0;
    int n_done_seen = 0;
    int n_done_exp = 0;

    always @(negedge clock) if (done === 1'b1) n_done_seen++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Called at a falling edge: drives a request across one rising edge (E0).
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit commit, output int e0);
        sb_t e;
        div_req = 1'b1; div_signed = sgn; rs_data = a; rt_data = b;
        @(negedge clock);
        div_req = 1'b0;
        e0 = cyc;
        if (commit) begin
            e.res = ref_div(sgn, a, b);
            e.e0 = e0;
            e.lat = (b == 32'd0) ? 2 : 36;
            e.starts = (b == 32'd0) ? 0 : 1;
            sb.push_back(e);
        end
    endtask

    // Waits (bounded) for done; returns on the falling edge where done is high.
    task automatic wait_done(input string tag, input bit inject);
        int nb = 0;
        int ns = 0;
        bit seen = 0;
        sb_t e;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (busy) nb++;
            if (core_start) ns++;
            if (done) begin
                seen = 1;
            end else begin
                if (inject && i == 5) begin
                    div_req = 1'b1; rt_data = 32'd0; rs_data = 32'h77; lo_we = 1'b1; wdata = 32'hDEAD;
                end
                @(negedge clock);
                div_req = 1'b0; lo_we = 1'b0;
            end
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            n_done_exp++;
            check({tag, "_hilo"}, {hi, lo}, e.res);
            check({tag, "_lat"}, 64'(cyc - e.e0), 64'(e.lat));
            check({tag, "_busy"}, 64'(nb), 64'(e.lat));
            check({tag, "_start"}, 64'(ns), 64'(e.starts));
        end
    endtask

    int e0;
    logic [31:0] sv_hi, sv_lo;
    logic [31:0] ra, rb;
    bit seen_err;

    initial begin
        reset = 1'b1; div_req = 1'b0; div_signed = 1'b0; rs_data = 32'd0; rt_data = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_ctl", {60'd0, busy, done, err, core_start}, 64'd0);

        issue(1'b0, 32'd100, 32'd7, 1'b1, e0);             wait_done("divu100_7", 1'b0);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, e0);       wait_done("div_m7_2", 1'b1);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, e0);       wait_done("div_7_m2", 1'b0);
        // back-to-back: next request issued on the done cycle
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e0); wait_done("div_min_m1", 1'b0);
        issue(1'b0, 32'h0000_1234, 32'd0, 1'b1, e0);       wait_done("div0", 1'b0);
        issue(1'b1, 32'h8000_0000, 32'd0, 1'b1, e0);       wait_done("div0_s", 1'b0);
        for (int k = 0; k < 4; k++) begin
            ra = $urandom; rb = $urandom_range(1, 65535);
            if (k[0]) rb = ~rb;
            issue(k[1], ra, rb, 1'b1, e0);                 wait_done("rand", 1'b0);
        end

        // MTLO in IDLE
        @(negedge clock);
        sv_hi = hi;
        lo_we = 1'b1; wdata = 32'h55;
        @(negedge clock);
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h55);
        check("mtlo_hi", 64'(hi), 64'(sv_hi));

        // Core hang: watchdog abort, MTLO and div_req during busy ignored
        sv_hi = hi; sv_lo = lo;
        core_hang = 1'b1;
        issue(1'b0, 32'd50, 32'd5, 1'b0, e0);
        seen_err = 0;
        for (int i = 0; i < 100 && !seen_err; i++) begin
            if (err) begin
                seen_err = 1;
            end else begin
                if (i == 5) begin
                    div_req = 1'b1; rt_data = 32'd0; rs_data = 32'h99; lo_we = 1'b1; wdata = 32'hBEEF;
                end
                @(negedge clock);
                div_req = 1'b0; lo_we = 1'b0;
            end
        end
        check("hang_err_seen", 64'(seen_err), 64'd1);
        check("hang_err_lat", 64'(cyc - e0), 64'(2 + TIMEOUT));
        check("hang_busy", 64'(busy), 64'd0);
        check("hang_hilo", {hi, lo}, {sv_hi, sv_lo});
        @(negedge clock);
        check("hang_err_pulse", 64'(err), 64'd0);
        repeat (5) @(negedge clock);
        check("hang_no_req", {62'd0, busy, core_start}, 64'd0);
        core_hang = 1'b0;

        // Reset mid-divide
        issue(1'b0, 32'd1000, 32'd3, 1'b1, e0);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        void'(sb.pop_front());
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        issue(1'b0, 32'd9, 32'd3, 1'b1, e0);               wait_done("after_rst", 1'b0);

        repeat (3) @(negedge clock);
        check("done_count", 64'(n_done_seen), 64'(n_done_exp));
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
